pipelined_weighted_adder_tree: RTL and testbench

//   Pipelined signed adder tree summing spike-gated synaptic weights: sum(spike[i] ? w[i] : 0)

---
 rtl/lif_pkg.sv | 31 +++
 rtl/tree_add_level.sv | 44 ++++
 rtl/pipelined_weighted_adder_tree.sv | 92 +++++++++
 tb/tb_pipelined_weighted_adder_tree.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared width helpers, weight type and saturation for the LIF datapath.
// Used by the adder tree (ADDER_TREE_SAT_EN) and the membrane block.
package lif_pkg;

  localparam int W_W_DEF = 4;

  typedef logic signed [W_W_DEF-1:0] weight_t;

  function automatic int level_w(input int w_w, input int k);
    return w_w + k;
  endfunction

  function automatic int full_w(input int w_w, input int n_stage);
    return w_w + n_stage;
  endfunction

  // Clip a sign-extended value to the signed out_w-bit range.
  function automatic logic signed [31:0] saturate(
    input logic signed [31:0] x,
    input int                 out_w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/tree_add_level.sv
// One registered level of the adder tree: N_PAIRS sign-extending adders.
// Pair j sums operands 2j and 2j+1 of the previous level.
module tree_add_level #(
  parameter int IN_W    = 4,
  parameter int N_PAIRS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic [2*N_PAIRS*IN_W-1:0]  in_data,
  output logic                       out_valid,
  output logic [N_PAIRS*(IN_W+1)-1:0] out_data
);

  localparam int OW = IN_W + 1;

  logic [N_PAIRS*OW-1:0] w_sum;
  logic [N_PAIRS*OW-1:0] r_data;
  logic                  r_valid;

  always_comb begin
    w_sum = '0;
    for (int j = 0; j < N_PAIRS; j++) begin
      w_sum[j*OW +: OW] =
        {in_data[(2*j+1)*IN_W-1], in_data[2*j*IN_W +: IN_W]} +
        {in_data[(2*j+2)*IN_W-1], in_data[(2*j+1)*IN_W +: IN_W]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (en) begin
      r_data  <= w_sum;
      r_valid <= in_valid;
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;

endmodule

// File: rtl/pipelined_weighted_adder_tree.sv
// Registered spike-gated weight adder tree, one level per enabled cycle.
// Define ADDER_TREE_SAT_EN for a saturating output and the sat_flag port.
module pipelined_weighted_adder_tree
  import lif_pkg::*;
#(
  parameter int N_STAGE = 4,
  parameter int W_W     = 4,
  parameter int OUT_W   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic [2**N_STAGE-1:0]      spikes,
  input  logic [2**N_STAGE*W_W-1:0]  weights,
  output logic                       out_valid,
  output logic [OUT_W-1:0]           y_out,
`ifdef ADDER_TREE_SAT_EN
  output logic                       sat_flag,
`endif
  output logic                       busy
);

  localparam int N_IN   = 2**N_STAGE;
  localparam int FULL_W = full_w(W_W, N_STAGE);

  logic [N_IN*W_W-1:0]      r_g;
  logic                     r_v0;
  logic [N_STAGE:0]         w_vbus;
  logic signed [FULL_W-1:0] w_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_g  <= '0;
      r_v0 <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < N_IN; i++) begin
        r_g[i*W_W +: W_W] <= spikes[i] ? weights[i*W_W +: W_W] : '0;
      end
      r_v0 <= in_valid;
    end
  end

  assign w_vbus[0] = r_v0;

  genvar k;
  for (k = 1; k <= N_STAGE; k++) begin : g_lvl
    localparam int IW = level_w(W_W, k - 1);
    localparam int NP = N_IN >> k;
    logic [2*NP*IW-1:0]   w_in;
    logic                 w_vin;
    logic [NP*(IW+1)-1:0] w_data;
    logic                 w_v;
    if (k == 1) begin : g_first
      assign w_in  = r_g;
      assign w_vin = r_v0;
    end else begin : g_next
      assign w_in  = g_lvl[k-1].w_data;
      assign w_vin = g_lvl[k-1].w_v;
    end
    tree_add_level #(
      .IN_W   (IW),
      .N_PAIRS(NP)
    ) u_lvl (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .in_valid (w_vin),
      .in_data  (w_in),
      .out_valid(w_v),
      .out_data (w_data)
    );
    assign w_vbus[k] = w_v;
  end

  assign w_sum     = g_lvl[N_STAGE].w_data;
  assign out_valid = w_vbus[N_STAGE];
  assign busy      = |w_vbus;

`ifdef ADDER_TREE_SAT_EN
  logic signed [31:0] w_wide;
  logic signed [31:0] w_clip;
  // Narrowing reads the final register, so the flag is registered with y_out.
  assign w_wide   = 32'(w_sum);
  assign w_clip   = saturate(w_wide, OUT_W);
  assign y_out    = w_clip[OUT_W-1:0];
  assign sat_flag = (w_clip != w_wide);
`else
  assign y_out = w_sum[OUT_W-1:0];
`endif

endmodule

// File: tb/tb_pipelined_weighted_adder_tree.sv
// Directed bench: default tree, an OUT_W=6 tree and an N_STAGE=1 tree.
// Expectations follow ADDER_TREE_SAT_EN when it is defined.
module tb_pipelined_weighted_adder_tree;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        in_valid;
  logic [15:0] spikes;
  logic [63:0] weights;
  logic        ov, ov6, busy, busy6;
  logic [7:0]  y;
  logic [5:0]  y6;
  logic        d1_iv;
  logic [1:0]  d1_sp;
  logic [3:0]  d1_w;
  logic        d1_ov, d1_busy;
  logic [2:0]  d1_y;
`ifdef ADDER_TREE_SAT_EN
  logic        sf, sf6, sf1;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_weighted_adder_tree u_dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
    .spikes(spikes), .weights(weights), .out_valid(ov), .y_out(y),
`ifdef ADDER_TREE_SAT_EN
    .sat_flag(sf),
`endif
    .busy(busy));

  pipelined_weighted_adder_tree #(.OUT_W(6)) u_d6 (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
    .spikes(spikes), .weights(weights), .out_valid(ov6), .y_out(y6),
`ifdef ADDER_TREE_SAT_EN
    .sat_flag(sf6),
`endif
    .busy(busy6));

  pipelined_weighted_adder_tree #(.N_STAGE(1), .W_W(2), .OUT_W(3)) u_d1 (
    .clk(clk), .reset(reset), .en(en), .in_valid(d1_iv),
    .spikes(d1_sp), .weights(d1_w), .out_valid(d1_ov), .y_out(d1_y),
`ifdef ADDER_TREE_SAT_EN
    .sat_flag(sf1),
`endif
    .busy(d1_busy));

  typedef struct {
    logic [15:0] sp;
    logic [63:0] w;
    logic [7:0]  y8;
    logic [5:0]  y6w;
    logic [5:0]  y6s;
    logic        f6;
  } vec_t;

  vec_t vt[7];
  logic [7:0] q[$];
  int got;
  logic pv;
  logic [7:0] py;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mon();
    if (ov) begin
      if (q.size() == 0) begin
        chk("stream_extra", 32'(ov), 32'd0);
      end else begin
        chk("stream_y", 32'(y), 32'(q.pop_front()));
        got++;
      end
    end
  endtask

  initial begin
    vt[0] = '{16'hFFFF, 64'h1111_1111_1111_1111, 8'h10, 6'h10, 6'h10, 1'b0};
    vt[1] = '{16'h5555, 64'h7654_3210_FEDC_BA98, 8'hF8, 6'h38, 6'h38, 1'b0};
    vt[2] = '{16'hFFFF, 64'h8888_8888_8888_8888, 8'h80, 6'h00, 6'h20, 1'b1};
    vt[3] = '{16'hFFFF, 64'h7777_7777_7777_7777, 8'h70, 6'h30, 6'h1F, 1'b1};
    vt[4] = '{16'h0000, 64'h7777_7777_7777_7777, 8'h00, 6'h00, 6'h00, 1'b0};
    vt[5] = '{16'h0001, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 6'h3F, 6'h3F, 1'b0};
    vt[6] = '{16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 6'h30, 6'h30, 1'b0};

    reset = 1'b1; en = 1'b1; in_valid = 1'b0;
    spikes = '0; weights = '0;
    d1_iv = 1'b0; d1_sp = '0; d1_w = '0;
    step(); step();
    chk("rst_ov", 32'(ov), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    reset = 1'b0;

    for (int n = 0; n < 7; n++) begin
      spikes = vt[n].sp; weights = vt[n].w; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int e = 1; e <= 5; e++) begin
        chk($sformatf("v%0d_busy_c%0d", n, e), 32'(busy), 32'd1);
        if (e < 5) begin
          chk($sformatf("v%0d_ov_c%0d", n, e), 32'(ov), 32'd0);
          step();
        end
      end
      chk($sformatf("v%0d_ov", n), 32'(ov), 32'd1);
      chk($sformatf("v%0d_y", n), 32'(y), 32'(vt[n].y8));
`ifdef ADDER_TREE_SAT_EN
      chk($sformatf("v%0d_y6", n), 32'(y6), 32'(vt[n].y6s));
      chk($sformatf("v%0d_sf6", n), 32'(sf6), 32'(vt[n].f6));
      chk($sformatf("v%0d_sf", n), 32'(sf), 32'd0);
`else
      chk($sformatf("v%0d_y6", n), 32'(y6), 32'(vt[n].y6w));
`endif
      step();
      chk($sformatf("v%0d_ov_after", n), 32'(ov), 32'd0);
      chk($sformatf("v%0d_busy_after", n), 32'(busy), 32'd0);
    end

    // Back-to-back stream with a 3-cycle stall while results are live.
    got = 0;
    for (int t = 0; t < 8; t++) begin
      spikes = 16'hFFFF;
      weights = {16{4'(t)}};
      in_valid = 1'b1;
      if (t == 6) begin
        en = 1'b0;
        for (int s = 0; s < 3; s++) begin
          pv = ov; py = y;
          step();
          chk("stall_ov", 32'(ov), 32'(pv));
          chk("stall_y", 32'(y), 32'(py));
        end
        en = 1'b1;
      end
      q.push_back(8'(16 * t));
      step();
      mon();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      mon();
    end
    chk("stream_count", 32'(got), 32'd8);
    chk("stream_left", 32'(q.size()), 32'd0);
    chk("stream_busy", 32'(busy), 32'd0);

    // Reset with three tokens in flight.
    spikes = 16'hFFFF;
    weights = {16{4'd3}};
    in_valid = 1'b1;
    step(); step(); step();
    reset = 1'b1;
    step();
    chk("mid_rst_ov", 32'(ov), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_y", 32'(y), 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("post_rst_ov_c%0d", c), 32'(ov), 32'd0);
    end

    // N_STAGE=1, W_W=2 tree: latency 2.
    d1_sp = 2'b11; d1_w = 4'b1010; d1_iv = 1'b1;
    step();
    d1_iv = 1'b0;
    chk("d1_ov_c1", 32'(d1_ov), 32'd0);
    chk("d1_busy_c1", 32'(d1_busy), 32'd1);
    step();
    chk("d1_ov_c2", 32'(d1_ov), 32'd1);
    chk("d1_y", 32'(d1_y), 32'h4);
`ifdef ADDER_TREE_SAT_EN
    chk("d1_sf", 32'(sf1), 32'd0);
`endif
    step();
    chk("d1_ov_c3", 32'(d1_ov), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
